// File: rtl/wb_arb2_pl.sv
// Two-master pipelined Wishbone arbiter with outstanding-request limit and timeout abort.
// Ports: clk_i/rst_i; m0_*/m1_* master buses; s_* slave bus.
module wb_arb2_pl #(
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int SEL_W   = 4,
    parameter int MAX_OUT = 15,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    input  logic [SEL_W-1:0] m0_sel_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    output logic [DAT_W-1:0] m0_dat_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    output logic             m0_stall_o,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    output logic [DAT_W-1:0] m1_dat_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic             m1_stall_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    output logic [SEL_W-1:0] s_sel_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    input  logic [DAT_W-1:0] s_dat_i,
    input  logic             s_ack_i,
    input  logic             s_err_i,
    input  logic             s_stall_i
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [15:0]      TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0]      TO_ONE  = 16'd1;

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, DRAIN} state_t;

    state_t           r_state;
    logic             r_last_grant;
    logic             r_abort_m;
    logic             r_abort_err;
    logic [CNT_W-1:0] r_out_cnt;
    logic [15:0]      r_to_cnt;

    logic w_g0, w_g1, w_full, w_cyc, w_resp, w_acc, w_dec, w_to_hit;

    assign w_g0   = (r_state == GRANT0);
    assign w_g1   = (r_state == GRANT1);
    assign w_full = (r_out_cnt == CNT_MAX);
    assign w_cyc  = w_g1 ? m1_cyc_i : m0_cyc_i;
    assign w_resp = s_ack_i | s_err_i;
    assign w_acc  = s_stb_o & ~s_stall_i;
    // An ack with nothing outstanding is forwarded but must not underflow.
    assign w_dec  = w_resp & (r_out_cnt != '0);
    assign w_to_hit = (r_out_cnt != '0) & ~w_resp & (r_to_cnt == TO_LAST);

    always_comb begin
        s_adr_o    = '0;
        s_dat_o    = '0;
        s_sel_o    = '0;
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        m0_dat_o   = '0;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m0_stall_o = 1'b1;
        m1_dat_o   = '0;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        m1_stall_o = 1'b1;
        case (r_state)
            GRANT0: begin
                s_adr_o    = m0_adr_i;
                s_dat_o    = m0_dat_i;
                s_sel_o    = m0_sel_i;
                s_we_o     = m0_we_i;
                s_cyc_o    = m0_cyc_i;
                s_stb_o    = m0_stb_i & m0_cyc_i & ~w_full;
                m0_stall_o = s_stall_i | w_full;
                m0_ack_o   = s_ack_i;
                m0_err_o   = s_err_i;
                m0_dat_o   = s_dat_i;
            end
            GRANT1: begin
                s_adr_o    = m1_adr_i;
                s_dat_o    = m1_dat_i;
                s_sel_o    = m1_sel_i;
                s_we_o     = m1_we_i;
                s_cyc_o    = m1_cyc_i;
                s_stb_o    = m1_stb_i & m1_cyc_i & ~w_full;
                m1_stall_o = s_stall_i | w_full;
                m1_ack_o   = s_ack_i;
                m1_err_o   = s_err_i;
                m1_dat_o   = s_dat_i;
            end
            DRAIN: begin
                // Abort error is a one-cycle pulse to the master that timed out.
                m0_err_o = r_abort_err & ~r_abort_m;
                m1_err_o = r_abort_err &  r_abort_m;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_abort_m    <= 1'b0;
            r_abort_err  <= 1'b0;
            r_out_cnt    <= '0;
            r_to_cnt     <= '0;
        end else begin
            r_abort_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_out_cnt <= '0;
                    r_to_cnt  <= '0;
                    if (m0_cyc_i && m1_cyc_i)
                        r_state <= r_last_grant ? GRANT0 : GRANT1;
                    else if (m0_cyc_i)
                        r_state <= GRANT0;
                    else if (m1_cyc_i)
                        r_state <= GRANT1;
                end
                GRANT0, GRANT1: begin
                    if (!w_cyc) begin
                        r_state      <= IDLE;
                        r_last_grant <= w_g1;
                        r_out_cnt    <= '0;
                        r_to_cnt     <= '0;
                    end else if (w_to_hit) begin
                        r_state     <= DRAIN;
                        r_abort_m   <= w_g1;
                        r_abort_err <= 1'b1;
                        r_out_cnt   <= '0;
                        r_to_cnt    <= '0;
                    end else begin
                        if (w_acc && !w_dec)
                            r_out_cnt <= r_out_cnt + CNT_ONE;
                        else if (!w_acc && w_dec)
                            r_out_cnt <= r_out_cnt - CNT_ONE;
                        if (r_out_cnt == '0 || w_resp)
                            r_to_cnt <= '0;
                        else
                            r_to_cnt <= r_to_cnt + TO_ONE;
                    end
                end
                DRAIN: begin
                    if (!(r_abort_m ? m1_cyc_i : m0_cyc_i)) begin
                        r_state      <= IDLE;
                        r_last_grant <= r_abort_m;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arb2_pl.sv
// Randomized self-checking bench for wb_arb2_pl against a behavioural model.
// Small MAX_OUT/TIMEOUT so the full and abort paths are reached often.
module tb_wb_arb2_pl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int MO = 2;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] m_adr [2];
    logic [DW-1:0] m_dat [2];
    logic [SW-1:0] m_sel [2];
    logic          m_cyc [2];
    logic          m_stb [2];
    logic          m_we  [2];
    logic [DW-1:0] m0_dat_o, m1_dat_o;
    logic          m0_ack_o, m0_err_o, m0_stall_o;
    logic          m1_ack_o, m1_err_o, m1_stall_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [SW-1:0] s_sel_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i, s_err_i, s_stall_i;

    always #5 clk = ~clk;

    wb_arb2_pl #(.ADR_W(AW), .DAT_W(DW), .SEL_W(SW),
                 .MAX_OUT(MO), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]),
        .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m0_stall_o(m0_stall_o),
        .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]),
        .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .m1_stall_o(m1_stall_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .s_stall_i(s_stall_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: owner -1 means no master holds the bus.
    int owner;
    bit draining;
    int aborted;
    bit abort_pulse;
    int last;
    int outst;
    int waited;

    task automatic model_reset();
        owner = -1; draining = 0; aborted = 0; abort_pulse = 0;
        last = 1; outst = 0; waited = 0;
    endtask

    task automatic model_out(output logic [127:0] es,
                             output logic [127:0] e0,
                             output logic [127:0] e1);
        logic [DW+2:0] r [2];
        logic full, stb;
        r[0] = {1'b1, 1'b0, 1'b0, {DW{1'b0}}};
        r[1] = r[0];
        es = '0;
        full = (outst == MO);
        if (!draining && owner >= 0) begin
            stb = m_stb[owner] & m_cyc[owner] & ~full;
            es = {m_cyc[owner], stb, m_we[owner], m_sel[owner],
                  m_adr[owner], m_dat[owner]};
            r[owner] = {s_stall_i | full, s_ack_i, s_err_i, s_dat_i};
        end else if (draining && abort_pulse) begin
            r[aborted][DW] = 1'b1;
        end
        e0 = 128'(r[0]);
        e1 = 128'(r[1]);
    endtask

    task automatic model_step();
        bit resp, acc;
        resp = s_ack_i | s_err_i;
        if (rst) begin
            model_reset();
            return;
        end
        abort_pulse = 0;
        if (draining) begin
            if (!m_cyc[aborted]) begin
                draining = 0; owner = -1; last = aborted;
            end
        end else if (owner < 0) begin
            if (m_cyc[0] && m_cyc[1]) owner = (last == 0) ? 1 : 0;
            else if (m_cyc[0]) owner = 0;
            else if (m_cyc[1]) owner = 1;
            outst = 0; waited = 0;
        end else if (!m_cyc[owner]) begin
            last = owner; owner = -1; outst = 0; waited = 0;
        end else if (outst > 0 && !resp && waited == TO - 1) begin
            draining = 1; aborted = owner; abort_pulse = 1;
            owner = -1; outst = 0; waited = 0;
        end else begin
            acc = m_stb[owner] && outst < MO && !s_stall_i;
            waited = (outst == 0 || resp) ? 0 : waited + 1;
            if (resp && outst > 0) outst--;
            if (acc) outst++;
        end
    endtask

    task automatic step();
        logic [127:0] es, e0, e1;
        #1;
        model_out(es, e0, e1);
        chk("slave_bus", {57'd0, s_cyc_o, s_stb_o, s_we_o, s_sel_o,
            s_adr_o, s_dat_o}, es);
        chk("m0_resp", {93'd0, m0_stall_o, m0_ack_o, m0_err_o,
            m0_dat_o}, e0);
        chk("m1_resp", {93'd0, m1_stall_o, m1_ack_o, m1_err_o,
            m1_dat_o}, e1);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic rand_in(input int ack_pct, input int cyc_div,
                           input int rst_div);
        for (int m = 0; m < 2; m++) begin
            if ($urandom_range(cyc_div - 1) == 0) m_cyc[m] = ~m_cyc[m];
            m_stb[m] = 1'($urandom_range(1));
            m_we[m]  = 1'($urandom_range(1));
            m_adr[m] = $urandom;
            m_dat[m] = $urandom;
            m_sel[m] = 4'($urandom_range(15));
        end
        s_dat_i   = $urandom;
        s_ack_i   = ($urandom_range(99) < ack_pct);
        s_err_i   = ($urandom_range(99) < 2);
        s_stall_i = ($urandom_range(3) == 0);
        rst       = ($urandom_range(rst_div - 1) == 0);
    endtask

    task automatic quiet();
        s_ack_i = 0; s_err_i = 0; s_stall_i = 0; rst = 0;
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            m_adr[m] = AW'(32'h100 * (m + 1));
            m_dat[m] = '0; m_sel[m] = '0;
            m_cyc[m] = 0; m_stb[m] = 0; m_we[m] = 0;
        end
        s_dat_i = 32'hA5A5_0000;
        quiet();
        model_reset();
        rst = 1;
        @(posedge clk); #1;
        step();
        chk("rst_s_cyc", 128'(s_cyc_o), 128'd0);
        chk("rst_m0_stall", 128'(m0_stall_o), 128'd1);
        chk("rst_m1_stall", 128'(m1_stall_o), 128'd1);
        rst = 0;

        // Tie after reset: m0 first, then m1 two cycles after m0 drops.
        m_cyc[0] = 1; m_cyc[1] = 1;
        step();
        chk("tie_m1_stall", 128'(m1_stall_o), 128'd1);
        chk("tie_s_adr", 128'(s_adr_o), 128'h100);
        m_cyc[0] = 0;
        step();
        chk("tie_idle_cyc", 128'(s_cyc_o), 128'd0);
        step();
        chk("tie_g1_adr", 128'(s_adr_o), 128'h200);
        m_cyc[1] = 0;
        step();
        step();

        // Fill to MAX_OUT with no acks, then ride out the timeout.
        m_cyc[0] = 1; m_stb[0] = 1;
        step();
        for (int i = 0; i < 3; i++) step();
        chk("full_stall", 128'(m0_stall_o), 128'd1);
        chk("full_no_stb", 128'(s_stb_o), 128'd0);
        for (int i = 0; i < 12; i++) step();
        chk("drain_cyc", 128'(s_cyc_o), 128'd0);
        m_cyc[0] = 0; m_stb[0] = 0;
        step();
        step();

        for (int i = 0; i < 2500; i++) begin
            rand_in(40, 12, 250);
            step();
        end
        for (int i = 0; i < 2500; i++) begin
            rand_in(4, 30, 400);
            step();
        end

        // Reset in the middle of a busy burst.
        quiet();
        m_cyc[1] = 1; m_stb[1] = 1; m_cyc[0] = 0;
        for (int i = 0; i < 4; i++) step();
        rst = 1;
        step();
        rst = 0;
        chk("mid_rst_s_cyc", 128'(s_cyc_o), 128'd0);
        chk("mid_rst_m1_stall", 128'(m1_stall_o), 128'd1);
        chk("mid_rst_m1_ack", 128'(m1_ack_o), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
